// File: rtl/vga_timing_pkg.sv
// XGA raster timing constants and the RAM-port scheduler state type.
// Shared by vga_raster_cnt and vga_scan_scheduler.
package vga_timing_pkg;

    localparam int unsigned XGA_H_VISIBLE = 1024;
    localparam int unsigned XGA_H_FP      = 24;
    localparam int unsigned XGA_H_SYNC    = 136;
    localparam int unsigned XGA_H_BP      = 160;
    localparam int unsigned XGA_V_VISIBLE = 768;
    localparam int unsigned XGA_V_FP      = 3;
    localparam int unsigned XGA_V_SYNC    = 6;
    localparam int unsigned XGA_V_BP      = 29;
    localparam int unsigned XGA_GUARD     = 2;

    localparam int unsigned XGA_H_TOTAL = XGA_H_VISIBLE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
    localparam int unsigned XGA_V_TOTAL = XGA_V_VISIBLE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;

    typedef enum logic [1:0] {
        DISP,
        IDLE,
        GRANT
    } sched_state_t;

endpackage

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with visible-area and capture-window flags.
// SCHED_HBLANK_EN also opens the capture window in horizontal blanking of visible lines.
module vga_raster_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = XGA_H_VISIBLE,
    parameter int unsigned H_TOTAL   = XGA_H_TOTAL,
    parameter int unsigned V_VISIBLE = XGA_V_VISIBLE,
    parameter int unsigned V_TOTAL   = XGA_V_TOTAL,
    parameter int unsigned GUARD     = XGA_GUARD
) (
    input  logic               clk,
    input  logic               rst,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               visible,
    output logic               window
);

    localparam logic [H_CNT_W-1:0] HLast  = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] HVis   = H_CNT_W'(H_VISIBLE);
    localparam logic [H_CNT_W-1:0] HGuard = H_CNT_W'(H_TOTAL - GUARD);
    localparam logic [V_CNT_W-1:0] VLast  = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] VVis   = V_CNT_W'(V_VISIBLE);

    logic frame_guard;
    logic vblank_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HLast) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VLast) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign visible = (h_cnt < HVis) && (v_cnt < VVis);

    // Last GUARD cycles of the frame give the capture engine time to let go before line 0.
    assign frame_guard = (v_cnt == VLast) && (h_cnt >= HGuard);
    assign vblank_win  = (v_cnt >= VVis) && !frame_guard;

`ifdef SCHED_HBLANK_EN
    logic hblank_win;
    assign hblank_win = (v_cnt < VVis) && (h_cnt >= HVis) && (h_cnt < HGuard);
    assign window     = vblank_win || hblank_win;
`else
    assign window = vblank_win;
`endif

endmodule

// File: rtl/vga_scan_scheduler.sv
// XGA raster generator that owns the sample-RAM port and lends it to capture in blanking.
// Define SCHED_HBLANK_EN to also lend the port during horizontal blanking.
module vga_scan_scheduler
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = XGA_H_VISIBLE,
    parameter int unsigned H_FP      = XGA_H_FP,
    parameter int unsigned H_SYNC    = XGA_H_SYNC,
    parameter int unsigned H_BP      = XGA_H_BP,
    parameter int unsigned V_VISIBLE = XGA_V_VISIBLE,
    parameter int unsigned V_FP      = XGA_V_FP,
    parameter int unsigned V_SYNC    = XGA_V_SYNC,
    parameter int unsigned V_BP      = XGA_V_BP,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned GUARD     = XGA_GUARD
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               de,
    output logic [10:0]        px_x,
    output logic [9:0]         px_y,
    output logic               frame_start,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               cap_req,
    output logic               cap_gnt,
    output logic               cap_abort
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] HsStart = H_CNT_W'(H_VISIBLE + H_FP);
    localparam logic [H_CNT_W-1:0] HsEnd   = H_CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [V_CNT_W-1:0] VsStart = V_CNT_W'(V_VISIBLE + V_FP);
    localparam logic [V_CNT_W-1:0] VsEnd   = V_CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               visible;
    logic               window;
    sched_state_t       state_q, state_d;

    vga_raster_cnt #(
        .H_VISIBLE (H_VISIBLE),
        .H_TOTAL   (H_TOTAL),
        .V_VISIBLE (V_VISIBLE),
        .V_TOTAL   (V_TOTAL),
        .GUARD     (GUARD)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .window  (window)
    );

    // Read side runs a cycle ahead of the pixel outputs; rst gating keeps it quiet in reset.
    assign rd_en   = visible && !rst;
    assign rd_addr = h_cnt[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync_n     <= !((h_cnt >= HsStart) && (h_cnt <= HsEnd));
            vsync_n     <= !((v_cnt >= VsStart) && (v_cnt <= VsEnd));
            de          <= visible;
            px_x        <= h_cnt;
            px_y        <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_abort = 1'b0;
        unique case (state_q)
            // A request left pending from display time is granted as soon as the window opens.
            DISP: begin
                if (window) begin
                    state_d = cap_req ? GRANT : IDLE;
                end
            end
            IDLE: begin
                if (!window) begin
                    state_d = DISP;
                end else if (cap_req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!window) begin
                    state_d   = DISP;
                    cap_abort = cap_req;
                end else if (!cap_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DISP;
        endcase
    end

    // Masking with window drops the grant in the very cycle the window closes.
    assign cap_gnt = (state_q == GRANT) && window;

endmodule
